mem_load_store_unit: RTL

- Memory-stage load/store unit of the 5-stage RV32I pipeline; produces the load-data word the writeback stage selects for register writeback.
- Accepts an access from the EX/MEM register: address = ALU result, store data = rs2, width/sign = funct3.
- Drives a single-outstanding req/ack data-memory bus, stalls the pipeline until the access completes, then aligns and sign/zero-extends the read data.
- Flags misaligned or illegal-funct3 accesses and bus timeouts.

---
 rtl/mem_load_store_unit_if.sv | 20 ++
 rtl/mem_load_store_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_load_store_unit_if.sv
// rtl/mem_load_store_unit_if.sv - single-outstanding req/ack data-memory bus
interface mem_load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_load_store_unit.sv
// rtl/mem_load_store_unit.sv - RV32I MEM-stage load/store unit with stall and bus timeout
module mem_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemEn_in,
    input  logic        MemRW_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    mem_load_store_unit_if.master bus,
    output logic [31:0] DataR_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} lsuState;

    localparam logic [9:0] LAST_CNT = 10'(TIMEOUT_CYCLES - 1);

    lsuState     state;
    logic [9:0]  waitCnt;
    logic [1:0]  addrLo;
    logic [2:0]  funct3Q;
    logic        illegal;
    logic        accessGo;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;
    logic [31:0] rdShift;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    always_comb begin
        illegal = 1'b0;
        case (funct3_in)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr_in[0];
            3'b010:  illegal = |addr_in[1:0];
            3'b100:  illegal = MemRW_in;
            3'b101:  illegal = MemRW_in | addr_in[0];
            default: illegal = 1'b1;
        endcase
    end

    assign accessGo     = (state == IDLE) && MemEn_in && !illegal;
    assign misalign_out = (state == IDLE) && MemEn_in && illegal;
    assign stall_out    = accessGo || (state == REQ);

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = wdata_in;
        case (funct3_in[1:0])
            2'b00: begin
                beNext    = 4'b0001 << addr_in[1:0];
                wdataNext = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                beNext    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{wdata_in[15:0]}};
            end
            default: ;
        endcase
        if (!MemRW_in) begin
            beNext = 4'b1111;
        end
    end

    // Lane extraction uses the byte offset captured at issue, not the live address.
    assign rdShift = bus.bus_rdata >> {addrLo, 3'b000};
    assign halfSel = addrLo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    always_comb begin
        loadData = bus.bus_rdata;
        case (funct3Q)
            3'b000:  loadData = {{24{rdShift[7]}}, rdShift[7:0]};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b100:  loadData = {24'd0, rdShift[7:0]};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            waitCnt       <= '0;
            addrLo        <= '0;
            funct3Q       <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            DataR_out     <= '0;
            bus_err_out   <= 1'b0;
        end else begin
            bus_err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accessGo) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= MemRW_in;
                        bus.bus_addr  <= {addr_in[31:2], 2'b00};
                        bus.bus_be    <= beNext;
                        bus.bus_wdata <= wdataNext;
                        addrLo        <= addr_in[1:0];
                        funct3Q       <= funct3_in;
                        waitCnt       <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            DataR_out <= loadData;
                        end
                        state <= DONE;
                    end else if (waitCnt == LAST_CNT) begin
                        // Abort: a timed-out load returns zero so writeback sees a defined value.
                        bus.bus_req <= 1'b0;
                        bus_err_out <= 1'b1;
                        if (!bus.bus_we) begin
                            DataR_out <= '0;
                        end
                        state <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 10'd1;
                    end
                end
                DONE: begin
                    waitCnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
